// File: rtl/gate_unit_pkg.sv
// -----------------------------------------------------------------------------
// gate_unit_pkg
// Shared definitions for the gate_unit_pipe slice: opcode encodings for the
// bitwise function evaluator, the output-buffer FSM state encoding and a
// parity helper used when the optional result flags are built in.
// No ports (package).
// -----------------------------------------------------------------------------
package gate_unit_pkg;

    // Function select encodings
    localparam logic [2:0] OP_AND  = 3'd0;
    localparam logic [2:0] OP_OR   = 3'd1;
    localparam logic [2:0] OP_NAND = 3'd2;
    localparam logic [2:0] OP_NOR  = 3'd3;
    localparam logic [2:0] OP_XOR  = 3'd4;
    localparam logic [2:0] OP_XNOR = 3'd5;
    localparam logic [2:0] OP_ANDN = 3'd6;
    localparam logic [2:0] OP_NOTA = 3'd7;

    // Occupancy of the 2-entry output buffer
    typedef enum logic [1:0] {
        ST_EMPTY = 2'd0,
        ST_ONE   = 2'd1,
        ST_TWO   = 2'd2
    } buf_state_e;

    // Even-parity bit (XOR reduction) of a zero-extended result
    function automatic logic parity32(input logic [31:0] v);
        return ^v;
    endfunction

endpackage

// File: rtl/gate_unit_func.sv
// -----------------------------------------------------------------------------
// gate_unit_func
// Purely combinational WIDTH-bit bitwise function evaluator; the multi-bit
// generalisation of the single-bit two-input gate modules.
// Ports:
//   op [2:0]        function select (OP_* in gate_unit_pkg)
//   a  [WIDTH-1:0]  operand A
//   b  [WIDTH-1:0]  operand B (ignored by NOTA)
//   f  [WIDTH-1:0]  result
// -----------------------------------------------------------------------------
module gate_unit_func
    import gate_unit_pkg::*;
#(
    parameter int WIDTH = 4
) (
    input  logic [2:0]       op,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic [WIDTH-1:0] f
);

    // Select the bitwise function of a and b
    always_comb begin
        f = {WIDTH{1'b0}};
        case (op)
            OP_AND:  f = a & b;
            OP_OR:   f = a | b;
            OP_NAND: f = ~(a & b);
            OP_NOR:  f = ~(a | b);
            OP_XOR:  f = a ^ b;
            OP_XNOR: f = ~(a ^ b);
            OP_ANDN: f = ~a & b;
            OP_NOTA: f = ~a;
            default: f = {WIDTH{1'b0}};
        endcase
    end

endmodule

// File: rtl/gate_unit_pipe.sv
// -----------------------------------------------------------------------------
// gate_unit_pipe
// Registered bitwise gate unit: evaluates one of eight functions on WIDTH-bit
// operands and delivers results through a 2-entry elastic FIFO with
// valid/ready on both sides. done_cnt counts output handshakes and wraps.
// Optional build macro: GATE_UNIT_FLAGS_EN adds out_zero / out_par, which
// travel with each buffered entry.
// Ports:
//   clk, reset           clock, synchronous active-high reset
//   in_valid / in_ready  operand handshake (a, b, op)
//   out_valid / out_ready result handshake (s)
//   s [WIDTH-1:0]        head of the buffer
//   done_cnt [CNT_W-1:0] completed output handshakes since reset
//   out_zero, out_par    (GATE_UNIT_FLAGS_EN only) flags of the head entry
// -----------------------------------------------------------------------------
module gate_unit_pipe
    import gate_unit_pkg::*;
#(
    parameter int WIDTH = 4,
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic [2:0]       op,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] s,
`ifdef GATE_UNIT_FLAGS_EN
    output logic             out_zero,
    output logic             out_par,
`endif
    output logic [CNT_W-1:0] done_cnt
);

    logic [WIDTH-1:0] w_f;
    logic             w_accept;
    logic             w_take;
    logic             w_in_ready;
    logic             w_out_valid;
    buf_state_e       r_state;
    buf_state_e       w_state_nxt;
    logic [CNT_W-1:0] r_cnt;

`ifdef GATE_UNIT_FLAGS_EN
    // Entry layout: {zero, par, result}; the reset entry reads as "zero result"
    localparam int EW = WIDTH + 2;
    localparam logic [EW-1:0] ENTRY_RST = {1'b1, 1'b0, {WIDTH{1'b0}}};
    logic [EW-1:0] w_entry;
    assign w_entry = {(w_f == {WIDTH{1'b0}}), parity32(32'(w_f)), w_f};
`else
    localparam int EW = WIDTH;
    localparam logic [EW-1:0] ENTRY_RST = {WIDTH{1'b0}};
    logic [EW-1:0] w_entry;
    assign w_entry = w_f;
`endif

    logic [EW-1:0] r_head;
    logic [EW-1:0] r_tail;

    gate_unit_func #(.WIDTH(WIDTH)) u_func (
        .op (op),
        .a  (a),
        .b  (b),
        .f  (w_f)
    );

    assign w_accept = in_valid & w_in_ready;
    assign w_take   = w_out_valid & out_ready;

    // Buffer state register
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= ST_EMPTY;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Buffer next-state logic
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            ST_EMPTY: begin
                if (w_accept) w_state_nxt = ST_ONE;
                else          w_state_nxt = r_state;
            end
            ST_ONE: begin
                if (w_accept && !w_take)      w_state_nxt = ST_TWO;
                else if (w_take && !w_accept) w_state_nxt = ST_EMPTY;
                else                          w_state_nxt = r_state;
            end
            ST_TWO: begin
                // in_ready is low here, so only a take can occur
                if (w_take) w_state_nxt = ST_ONE;
                else        w_state_nxt = r_state;
            end
            default: w_state_nxt = ST_EMPTY;
        endcase
    end

    // Handshake outputs decoded from the buffer state
    always_comb begin
        w_out_valid = (r_state != ST_EMPTY);
        w_in_ready  = (r_state != ST_TWO) && !reset;
    end

    // Head/tail entry storage; head is always the oldest result
    always_ff @(posedge clk) begin
        if (reset) begin
            r_head <= ENTRY_RST;
            r_tail <= ENTRY_RST;
        end else begin
            case (r_state)
                ST_EMPTY: begin
                    if (w_accept) r_head <= w_entry;
                end
                ST_ONE: begin
                    if (w_accept && !w_take)     r_tail <= w_entry;
                    else if (w_accept && w_take) r_head <= w_entry;
                end
                ST_TWO: begin
                    if (w_take) r_head <= r_tail;
                end
                default: begin
                    r_head <= ENTRY_RST;
                    r_tail <= ENTRY_RST;
                end
            endcase
        end
    end

    // Completed-result counter, wraps naturally at 2^CNT_W
    always_ff @(posedge clk) begin
        if (reset) begin
            r_cnt <= {CNT_W{1'b0}};
        end else if (w_take) begin
            r_cnt <= r_cnt + CNT_W'(1'b1);
        end
    end

    assign in_ready  = w_in_ready;
    assign out_valid = w_out_valid;
    assign s         = r_head[WIDTH-1:0];
    assign done_cnt  = r_cnt;
`ifdef GATE_UNIT_FLAGS_EN
    assign out_zero  = r_head[WIDTH+1];
    assign out_par   = r_head[WIDTH];
`endif

endmodule

// File: tb/tb_gate_unit_pipe.sv
// -----------------------------------------------------------------------------
// tb_gate_unit_pipe
// Scoreboard bench for gate_unit_pipe (WIDTH=4, CNT_W=4 so the counter wraps
// quickly). Expected results are queued when an accept is predicted and
// compared against s while the model says the buffer is non-empty.
// Honours GATE_UNIT_FLAGS_EN for the optional flag outputs.
// -----------------------------------------------------------------------------
module tb_gate_unit_pipe;

    localparam int WIDTH = 4;
    localparam int CNT_W = 4;

    logic             clk = 1'b0;
    logic             reset;
    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic [2:0]       op;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] s;
    logic [CNT_W-1:0] done_cnt;
`ifdef GATE_UNIT_FLAGS_EN
    logic             out_zero;
    logic             out_par;
`endif

    int n_checks = 0;
    int n_errors = 0;
    logic [WIDTH-1:0] exp_q[$];
    logic [CNT_W-1:0] exp_cnt;
    logic [WIDTH-1:0] sweep_tbl [8] = '{4'b0001, 4'b0111, 4'b1110, 4'b1000,
                                        4'b0110, 4'b1001, 4'b0100, 4'b1100};

    always #5 clk = ~clk;

    gate_unit_pipe #(.WIDTH(WIDTH), .CNT_W(CNT_W)) dut (
        .clk       (clk),
        .reset     (reset),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .a         (a),
        .b         (b),
        .op        (op),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .s         (s),
`ifdef GATE_UNIT_FLAGS_EN
        .out_zero  (out_zero),
        .out_par   (out_par),
`endif
        .done_cnt  (done_cnt)
    );

    task automatic check_val(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, act, exp);
        end
    endtask

    // Reference function for the eight opcodes
    function automatic logic [WIDTH-1:0] gold(input logic [2:0] o, input logic [WIDTH-1:0] x,
                                              input logic [WIDTH-1:0] y);
        case (o)
            3'd0:    return x & y;
            3'd1:    return x | y;
            3'd2:    return ~(x & y);
            3'd3:    return ~(x | y);
            3'd4:    return x ^ y;
            3'd5:    return ~(x ^ y);
            3'd6:    return (~x) & y;
            3'd7:    return ~x;
            default: return {WIDTH{1'b0}};
        endcase
    endfunction

    // One clock cycle: inputs were driven just after a negedge; check the
    // visible state against the model, predict handshakes, advance the model
    task automatic tick(input string tag, input logic [WIDTH-1:0] exp_f);
        logic acc;
        logic tk;
        #1;
        check_val({tag, "_ovld"}, 32'(out_valid), 32'(exp_q.size() != 0));
        check_val({tag, "_irdy"}, 32'(in_ready), 32'((exp_q.size() < 2) && !reset));
        if (exp_q.size() != 0) begin
            check_val({tag, "_s"}, 32'(s), 32'(exp_q[0]));
`ifdef GATE_UNIT_FLAGS_EN
            check_val({tag, "_zero"}, 32'(out_zero), 32'(exp_q[0] == 4'h0));
            check_val({tag, "_par"}, 32'(out_par), 32'(^exp_q[0]));
`endif
        end
        acc = in_valid && !reset && (exp_q.size() < 2);
        tk  = out_ready && (exp_q.size() != 0);
        @(posedge clk);
        if (reset) begin
            exp_q.delete();
            exp_cnt = 4'd0;
        end else begin
            if (tk) begin
                void'(exp_q.pop_front());
                exp_cnt = exp_cnt + 4'd1;
            end
            if (acc) exp_q.push_back(exp_f);
        end
        @(negedge clk);
        check_val({tag, "_cnt"}, 32'(done_cnt), 32'(exp_cnt));
    endtask

    task automatic drive(input logic v, input logic [2:0] o, input logic [WIDTH-1:0] x,
                         input logic [WIDTH-1:0] y, input logic rdy);
        in_valid  = v;
        op        = o;
        a         = x;
        b         = y;
        out_ready = rdy;
    endtask

    task automatic drain(input string tag);
        drive(1'b0, 3'd0, 4'h0, 4'h0, 1'b1);
        for (int i = 0; i < 8 && exp_q.size() != 0; i++) tick(tag, 4'h0);
        check_val({tag, "_empty"}, 32'(exp_q.size()), 32'd0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        logic [WIDTH-1:0] ra;
        logic [WIDTH-1:0] rb;
        logic [2:0]       ro;
        exp_cnt = 4'd0;
        reset   = 1'b1;
        drive(1'b0, 3'd0, 4'h0, 4'h0, 1'b0);
        repeat (2) @(negedge clk);

        // Reset state
        tick("rst", 4'h0);
        reset = 1'b0;
        #1;
        check_val("rst_ovld", 32'(out_valid), 32'd0);
        check_val("rst_s", 32'(s), 32'd0);
        check_val("rst_cnt", 32'(done_cnt), 32'd0);
        check_val("rst_irdy", 32'(in_ready), 32'd1);
`ifdef GATE_UNIT_FLAGS_EN
        check_val("rst_zero", 32'(out_zero), 32'd1);
        check_val("rst_par", 32'(out_par), 32'd0);
`endif
        @(negedge clk);

        // Opcode sweep, back-to-back with out_ready=1
        for (int k = 0; k < 8; k++) begin
            drive(1'b1, 3'(k), 4'b0011, 4'b0101, 1'b1);
            tick("sweep", sweep_tbl[k]);
        end
        drain("sweep_drain");
        check_val("sweep_done_cnt", 32'(done_cnt), 32'd8);

        // Backpressure: three attempts, only two fit
        drive(1'b1, 3'd4, 4'h9, 4'h5, 1'b0);
        tick("bp1", gold(3'd4, 4'h9, 4'h5));
        drive(1'b1, 3'd2, 4'hF, 4'h6, 1'b0);
        tick("bp2", gold(3'd2, 4'hF, 4'h6));
        check_val("bp_full_irdy", 32'(in_ready), 32'd0);
        drive(1'b1, 3'd1, 4'h2, 4'h4, 1'b0);
        tick("bp3", gold(3'd1, 4'h2, 4'h4));
        check_val("bp_held_s", 32'(s), 32'hC);
        drain("bp_drain");

        // Simultaneous accept and take while holding one entry
        drive(1'b1, 3'd4, 4'h9, 4'h3, 1'b0);
        tick("sim1", 4'hA);
        drive(1'b1, 3'd1, 4'h8, 4'h1, 1'b1);
        tick("sim2", 4'h9);
        #1;
        check_val("sim_s", 32'(s), 32'h9);
        check_val("sim_ovld", 32'(out_valid), 32'd1);
        check_val("sim_irdy", 32'(in_ready), 32'd1);
        drain("sim_drain");

        // Reset with the buffer full; in_valid during reset is ignored
        drive(1'b1, 3'd0, 4'hF, 4'hF, 1'b0);
        tick("mr1", 4'hF);
        drive(1'b1, 3'd3, 4'h0, 4'h0, 1'b0);
        tick("mr2", 4'hF);
        reset = 1'b1;
        drive(1'b1, 3'd1, 4'h5, 4'h5, 1'b0);
        tick("mr_rst", 4'h5);
        reset = 1'b0;
        drive(1'b0, 3'd0, 4'h0, 4'h0, 1'b1);
        #1;
        check_val("mr_ovld", 32'(out_valid), 32'd0);
        check_val("mr_s", 32'(s), 32'd0);
        check_val("mr_cnt", 32'(done_cnt), 32'd0);
        check_val("mr_irdy", 32'(in_ready), 32'd1);
        @(negedge clk);
        tick("mr_idle", 4'h0);

        // Counter wrap: 17 takes with random operands
        for (int k = 0; k < 17; k++) begin
            ra = 4'($urandom_range(0, 15));
            rb = 4'($urandom_range(0, 15));
            ro = 3'($urandom_range(0, 7));
            drive(1'b1, ro, ra, rb, 1'b1);
            tick("wrap", gold(ro, ra, rb));
        end
        drain("wrap_drain");
        check_val("wrap_cnt", 32'(done_cnt), 32'd1);

`ifdef GATE_UNIT_FLAGS_EN
        // Flag values for a zero and a non-zero result
        drive(1'b1, 3'd4, 4'hA, 4'hA, 1'b1);
        tick("flg1", 4'h0);
        drive(1'b0, 3'd0, 4'h0, 4'h0, 1'b0);
        #1;
        check_val("flg1_s", 32'(s), 32'h0);
        check_val("flg1_zero", 32'(out_zero), 32'd1);
        check_val("flg1_par", 32'(out_par), 32'd0);
        drive(1'b1, 3'd1, 4'h1, 4'h2, 1'b1);
        tick("flg2", 4'h3);
        drive(1'b0, 3'd0, 4'h0, 4'h0, 1'b0);
        #1;
        check_val("flg2_s", 32'(s), 32'h3);
        check_val("flg2_zero", 32'(out_zero), 32'd0);
        check_val("flg2_par", 32'(out_par), 32'd0);
        @(negedge clk);
        drain("flg_drain");
`endif

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
